// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SCAN,
        DONE
    } disp_state_t;

    localparam int          NDIG     = 8;
    localparam int          BCD_W    = 36;
    localparam logic [3:0]  BCD_ERR  = 4'hE;
    localparam logic [26:0] DISP_MAX = 27'd99_999_999;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: loads on start, one shift per cycle for WIDTH cycles,
// then pulses ready for one cycle; bcd/ovf hold until the next start.
module bin2bcd_seq #(
    parameter int WIDTH = 27
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [WIDTH-1:0]         bin,
    output logic [calc_pkg::BCD_W-1:0] bcd,
    output logic                     ovf,
    output logic                     ready
);
    import calc_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_d;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             ready_q;

    // Add-3 correction happens before the shift, on the current register contents.
    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (start) begin
                bin_q <= bin;
                bcd_q <= '0;
                cnt_q <= CW'(WIDTH);
                run_q <= 1'b1;
            end else if (run_q) begin
                bcd_q <= {adj_d[BCD_W-2:0], bin_q[WIDTH-1]};
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    run_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            end
        end
    end

    assign bcd   = bcd_q;
    assign ovf   = |bcd_q[BCD_W-1 -: 4];
    assign ready = ready_q;

endmodule

// File: rtl/calc_display_sched.sv
// Round-robin display scheduler: grant, WIDTH-cycle BCD conversion, NDIG-digit scan, done pulse.
// Requests are level-held and only arbitrated while idle; 37-cycle refresh period at defaults.
module calc_display_sched #(
    parameter int WIDTH = 27,
    parameter int NDIG  = calc_pkg::NDIG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] val_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] val_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy,
    output logic [3:0]       pos,
    output logic [3:0]       data,
    output logic             data_valid,
    output logic             ovf,
    output logic             done
);
    import calc_pkg::*;

    logic             conv_start;
    logic [WIDTH-1:0] conv_bin;
    logic [BCD_W-1:0] conv_bcd;
    logic             conv_ovf;
    logic             conv_ready;

    disp_state_t state_q;
    logic        last_b_q;
    logic        gnt_a_q, gnt_b_q, busy_q, dv_q, ovf_q, done_q;
    logic [3:0]  pos_q, data_q;

    logic        pick_a, pick_b, ovf_d;
    logic [3:0]  pos_d, digit_d;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        pick_a     = req_a && (!req_b || last_b_q);
        pick_b     = req_b && !pick_a;
        conv_start = (state_q == IDLE) && (req_a || req_b);
        conv_bin   = pick_a ? val_a : val_b;
        pos_d      = (state_q == SCAN) ? pos_q + 4'd1 : 4'd0;
        ovf_d      = (state_q == CONVERT) ? conv_ovf : ovf_q;
        digit_d    = ovf_d ? BCD_ERR : conv_bcd[4*pos_d +: 4];
    end

    bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
        .clock (clock),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf),
        .ready (conv_ready)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            pos_q    <= 4'd0;
            data_q   <= 4'd0;
        end else begin
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (conv_start) begin
                        gnt_a_q  <= pick_a;
                        gnt_b_q  <= pick_b;
                        last_b_q <= pick_b;
                        busy_q   <= 1'b1;
                        ovf_q    <= 1'b0;
                        state_q  <= CONVERT;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                CONVERT: begin
                    if (conv_ready) begin
                        dv_q    <= 1'b1;
                        ovf_q   <= ovf_d;
                        pos_q   <= pos_d;
                        data_q  <= digit_d;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    pos_q  <= pos_d;
                    data_q <= digit_d;
                    if (pos_d == 4'(NDIG - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    dv_q    <= 1'b0;
                    pos_q   <= 4'd0;
                    data_q  <= 4'd0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_a      = gnt_a_q;
    assign gnt_b      = gnt_b_q;
    assign busy       = busy_q;
    assign pos        = pos_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign ovf        = ovf_q;
    assign done       = done_q;

endmodule

// File: tb/tb_calc_display_sched.sv
// Directed bench for calc_display_sched; digits are packed with pos 0 in the low nibble.
module tb_calc_display_sched;

    logic        clock;
    logic        reset;
    logic        req_a, req_b;
    logic [26:0] val_a, val_b;
    logic        gnt_a, gnt_b, busy, data_valid, ovf, done;
    logic [3:0]  pos, data;

    int total = 0;
    int bad   = 0;

    calc_display_sched dut (
        .clock      (clock),
        .reset      (reset),
        .req_a      (req_a),
        .val_a      (val_a),
        .req_b      (req_b),
        .val_b      (val_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .busy       (busy),
        .pos        (pos),
        .data       (data),
        .data_valid (data_valid),
        .ovf        (ovf),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Steps t1..t36 after a grant seen at t0 and gathers what the scan produced.
    task automatic observe(output logic [31:0] digs, output logic ovf_s, output int dv_cnt,
                           output logic pos_ok, output int done_cnt, output logic done_t36,
                           output logic gnt_seen);
        digs = '0; ovf_s = 1'b0; dv_cnt = 0; pos_ok = 1'b1;
        done_cnt = 0; done_t36 = 1'b0; gnt_seen = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clock);
            if (gnt_a || gnt_b) gnt_seen = 1'b1;
            if (done) done_cnt++;
            if (c == 36) done_t36 = done && !data_valid && (pos == 4'd0) && (data == 4'd0);
            if (data_valid) begin
                dv_cnt++;
                if (c >= 28 && c <= 35 && pos == 4'(c - 28)) begin
                    digs[4*(c-28) +: 4] = data;
                    if (c == 28) ovf_s = ovf;
                end else begin
                    pos_ok = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0; val_a = '0; val_b = '0;
        repeat (3) @(negedge clock);
        total++;
        if ({gnt_a, gnt_b, busy, data_valid, done, ovf, pos, data} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0",
                     {gnt_a, gnt_b, busy, data_valid, done, ovf, pos, data});
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({gnt_a, gnt_b, busy, done} !== 4'd0) begin
            bad++;
            $display("FAIL idle_no_req: got %b want 0000", {gnt_a, gnt_b, busy, done});
        end
    endtask

    task automatic test_single_a;
        logic [31:0] digs; logic ovf_s, pos_ok, done_t36, gnt_seen; int dv_cnt, done_cnt;
        req_a = 1'b1; val_a = 27'd1234;
        @(negedge clock);
        total++;
        if ({gnt_a, gnt_b, busy} !== 3'b101) begin
            bad++;
            $display("FAIL single_grant: got gnt_a/gnt_b/busy=%b want 101", {gnt_a, gnt_b, busy});
        end
        req_a = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h0000_1234 || ovf_s !== 1'b0) begin
            bad++;
            $display("FAIL single_digits: got %h ovf=%b want 00001234 ovf=0", digs, ovf_s);
        end
        total++;
        if (dv_cnt != 8 || !pos_ok || done_cnt != 1 || !done_t36) begin
            bad++;
            $display("FAIL single_timing: got dv=%0d pos_ok=%b done=%0d done_t36=%b want 8 1 1 1",
                     dv_cnt, pos_ok, done_cnt, done_t36);
        end
        @(negedge clock);
        total++;
        if ({busy, done, data_valid} !== 3'b000) begin
            bad++;
            $display("FAIL single_back_idle: got busy/done/dv=%b want 000", {busy, done, data_valid});
        end
    endtask

    task automatic test_tie;
        logic [31:0] digs; logic ovf_s, pos_ok, done_t36, gnt_seen; int dv_cnt, done_cnt;
        reset = 1'b1; req_a = 1'b1; req_b = 1'b1; val_a = 27'd42; val_b = 27'd7;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        total++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            bad++;
            $display("FAIL tie_first: got gnt_a/gnt_b=%b want 10", {gnt_a, gnt_b});
        end
        req_a = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h0000_0042 || gnt_seen !== 1'b0) begin
            bad++;
            $display("FAIL tie_a_scan: got %h gnt_seen=%b want 00000042 gnt_seen=0", digs, gnt_seen);
        end
        @(negedge clock);
        total++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            bad++;
            $display("FAIL tie_b_at_t37: got gnt_a/gnt_b=%b want 01", {gnt_a, gnt_b});
        end
        req_b = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h0000_0007 || dv_cnt != 8 || !done_t36) begin
            bad++;
            $display("FAIL tie_b_scan: got %h dv=%0d done_t36=%b want 00000007 8 1",
                     digs, dv_cnt, done_t36);
        end
    endtask

    task automatic test_max_ovf;
        logic [31:0] digs; logic ovf_s, pos_ok, done_t36, gnt_seen; int dv_cnt, done_cnt;
        req_b = 1'b1; val_b = calc_pkg::DISP_MAX;
        @(negedge clock);
        total++;
        if (gnt_b !== 1'b1) begin
            bad++;
            $display("FAIL max_grant: got gnt_b=%b want 1", gnt_b);
        end
        req_b = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h9999_9999 || ovf_s !== 1'b0) begin
            bad++;
            $display("FAIL max_digits: got %h ovf=%b want 99999999 ovf=0", digs, ovf_s);
        end
        req_b = 1'b1; val_b = 27'd100_000_000;
        @(negedge clock);
        req_b = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'hEEEE_EEEE || ovf_s !== 1'b1 || !pos_ok) begin
            bad++;
            $display("FAIL ovf_digits: got %h ovf=%b pos_ok=%b want eeeeeeee ovf=1 pos_ok=1",
                     digs, ovf_s, pos_ok);
        end
        @(negedge clock);
        total++;
        if ({ovf, busy} !== 2'b10) begin
            bad++;
            $display("FAIL ovf_held: got ovf/busy=%b want 10", {ovf, busy});
        end
    endtask

    task automatic test_zero;
        logic [31:0] digs; logic ovf_s, pos_ok, done_t36, gnt_seen; int dv_cnt, done_cnt;
        req_a = 1'b1; val_a = 27'd0;
        @(negedge clock);
        total++;
        if ({gnt_a, ovf} !== 2'b10) begin
            bad++;
            $display("FAIL zero_grant_ovf_clear: got gnt_a/ovf=%b want 10", {gnt_a, ovf});
        end
        req_a = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h0 || dv_cnt != 8 || !pos_ok) begin
            bad++;
            $display("FAIL zero_scan: got %h dv=%0d pos_ok=%b want 00000000 8 1", digs, dv_cnt, pos_ok);
        end
    endtask

    task automatic test_busy_req;
        logic [31:0] digs; logic ovf_s, pos_ok, done_t36, gnt_seen; int dv_cnt, done_cnt;
        logic early;
        early = 1'b0;
        req_a = 1'b1; val_a = 27'd55;
        @(negedge clock);
        req_a = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clock);
            if (c == 5) begin req_b = 1'b1; val_b = 27'd300; end
            if (gnt_a || gnt_b) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++;
            $display("FAIL busy_no_grant: got early grant=%b want 0", early);
        end
        @(negedge clock);
        total++;
        if ({gnt_a, gnt_b} !== 2'b01) begin
            bad++;
            $display("FAIL busy_grant_t37: got gnt_a/gnt_b=%b want 01", {gnt_a, gnt_b});
        end
        req_b = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h0000_0300) begin
            bad++;
            $display("FAIL busy_b_digits: got %h want 00000300", digs);
        end
    endtask

    task automatic test_mid_reset;
        logic [31:0] digs; logic ovf_s, pos_ok, done_t36, gnt_seen; int dv_cnt, done_cnt;
        req_a = 1'b1; val_a = 27'd1234;
        @(negedge clock);
        req_a = 1'b0;
        repeat (29) @(negedge clock);
        total++;
        if ({data_valid, pos} !== 5'b1_0001) begin
            bad++;
            $display("FAIL mid_scan_pos: got dv/pos=%b want 10001", {data_valid, pos});
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({gnt_a, gnt_b, busy, data_valid, done, ovf, pos, data} !== 14'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b want 0",
                     {gnt_a, gnt_b, busy, data_valid, done, ovf, pos, data});
        end
        reset = 1'b0; req_a = 1'b1; val_a = 27'd9;
        @(negedge clock);
        total++;
        if ({gnt_a, done} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_grant: got gnt_a/done=%b want 10", {gnt_a, done});
        end
        req_a = 1'b0;
        observe(digs, ovf_s, dv_cnt, pos_ok, done_cnt, done_t36, gnt_seen);
        total++;
        if (digs !== 32'h0000_0009 || done_cnt != 1) begin
            bad++;
            $display("FAIL post_reset_scan: got %h done=%0d want 00000009 1", digs, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_tie();
        test_max_ovf();
        test_zero();
        test_busy_req();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_display_sched.md
# calc_display_sched

Sequential display scheduler for the calculator's 8-digit 7-segment bus. Two requesters share the single `pos`/`data` scan path: the operand-entry path (A) and the result path (B). A round-robin arbiter picks one request. The block converts the 27-bit binary value to BCD with a sequential double-dabble, then scans the eight digits out one per cycle. It sits between the calculator datapath and the display decoder.

## Interface
- `WIDTH`, default 27: width of the binary value.
- `NDIG`, default 8: number of display digits scanned.
- `clock` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req_a` input 1: entry path requests a display refresh; level, held until `gnt_a`.
- `val_a` input WIDTH: value to show for A; must be stable while `req_a` is high.
- `req_b` input 1: result path request; level, held until `gnt_b`.
- `val_b` input WIDTH: value to show for B.
- `gnt_a` output 1: one-cycle pulse; `val_a` is captured in this cycle.
- `gnt_b` output 1: one-cycle pulse; `val_b` is captured in this cycle.
- `busy` output 1: high in every state except IDLE.
- `pos` output 4: digit index being driven, 0 = least significant.
- `data` output 4: BCD digit for `pos`, or 4'hE on overflow.
- `data_valid` output 1: `pos`/`data` are meaningful this cycle.
- `ovf` output 1: value exceeds 99_999_999; valid with `data_valid`, held until the next grant.
- `done` output 1: one-cycle pulse after the last digit.

## Operation
- Reset values:
  - `gnt_a`, `gnt_b`, `busy`, `data_valid`, `done`, `ovf` = 0.
  - `pos` = 0, `data` = 0.
  - Internal `last_gnt` = B, so A wins the first tie.
  - State = IDLE.
- States are IDLE, CONVERT, SCAN, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the one not equal to `last_gnt`.
  - On any grant: pulse the grant, capture the value into the shift register, clear the 36-bit BCD register, update `last_gnt`, go to CONVERT.
- CONVERT runs WIDTH cycles. Each cycle:
  - add 3 to every BCD nibble that is >= 5;
  - then shift {bcd, bin} left by one.
  - After the WIDTH-th shift, go to SCAN.
- Overflow: at the CONVERT→SCAN transition, `ovf` = 1 if BCD nibble 8 (the ninth digit) is nonzero.
- SCAN runs NDIG cycles with `data_valid` = 1.
  - `pos` counts 0..NDIG-1.
  - `data` = BCD nibble `pos`, or 4'hE if `ovf`.
  - After `pos` = NDIG-1, go to DONE.
- DONE lasts one cycle: `done` = 1, `data_valid` = 0, `pos` = 0, then go to IDLE.
- Requests seen while `busy`: not granted and not lost. They are arbitrated in the next IDLE cycle.
- Values are unsigned. Wrapped subtraction results show as large numbers or as overflow.
- No leading-zero blanking; all NDIG digits are always emitted.
- Outside SCAN, `data` = 0 and `pos` = 0.
- Reset in any state returns every output to its reset value on the next edge. A partial scan is abandoned and `done` does not fire.

## Timing
- Grant in cycle t0. CONVERT occupies t1..t27.
- SCAN occupies t28..t35: `pos` 0..7 with `data_valid` high.
- `done` at t36. IDLE at t37, where the next grant can occur.
- Request-to-grant latency is 0 cycles when idle.
- Back-to-back refresh period is 37 cycles.
- Outputs are registered; no combinational path from `req_*` to `gnt_*`.

## Structure
- Shared package `calc_pkg` holds:
  - the `disp_state_t` enum (IDLE, CONVERT, SCAN, DONE);
  - `NDIG` and `BCD_ERR` = 4'hE;
  - `DISP_MAX` = 27'd99_999_999.
- Sub-module `bin2bcd_seq` is the sequential double-dabble.
  - Inputs: `start`, `bin`.
  - Outputs: `bcd[35:0]`, `ovf`, one-cycle `ready` after WIDTH shifts.
- The scheduler keeps the arbiter, FSM and scan counter.

## Test plan
- After reset, `req_a` = 1 with `val_a` = 1234 → `gnt_a` at t0; t28..t35 `data` = 4,3,2,1,0,0,0,0 on `pos` 0..7; `done` at t36; `ovf` = 0.
- `req_a` and `req_b` both held from reset, `val_b` = 7 → `gnt_a` first; `gnt_b` at t37; second scan shows 7,0,0,0,0,0,0,0.
- `val_b` = 99_999_999 → all digits 9, `ovf` = 0. `val_b` = 100_000_000 → all digits 4'hE, `ovf` = 1.
- Reset asserted at t30 (mid-SCAN) → next cycle all outputs 0, no `done`. A fresh `req_a` is granted immediately after reset deasserts.
- `req_b` raised at t5 during A's refresh → no grant while `busy`; `gnt_b` at t37.
- Value 0 → eight 0 digits; `data_valid` high for exactly 8 cycles.
